// File: rtl/fir_param_if.sv
// fir_param_if -- signal bundle for the fir_param filter.
//   master : drives samples (x_n, s_axis_fir_tvalid) and coefficients
//            (s_set_coeffs, coeff_in); receives y_n, m_axis_fir_tvalid
//            and coeffs_done.
//   slave  : the filter side of the same signals.
// Widths must match the parameters of the attached fir_param instance.
interface fir_param_if #(
    parameter int TAP_SIZE = 4,
    parameter int X_N_SIZE = 8,
    parameter int Y_N_SIZE = 12
);
    logic signed [X_N_SIZE-1:0] x_n;
    logic                       s_axis_fir_tvalid;
    logic                       s_set_coeffs;
    logic signed [TAP_SIZE-1:0] coeff_in;
    logic signed [Y_N_SIZE-1:0] y_n;
    logic                       m_axis_fir_tvalid;
    logic                       coeffs_done;

    modport master (
        output x_n, s_axis_fir_tvalid, s_set_coeffs, coeff_in,
        input  y_n, m_axis_fir_tvalid, coeffs_done
    );

    modport slave (
        input  x_n, s_axis_fir_tvalid, s_set_coeffs, coeff_in,
        output y_n, m_axis_fir_tvalid, coeffs_done
    );
endinterface

// File: rtl/fir_param.sv
// fir_param -- parameterised direct-form FIR filter with serial coefficient
// loading and a saturated, registered output.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; restores the identity filter
//   bus   : fir_param_if.slave
//           x_n / s_axis_fir_tvalid      : input sample stream
//           s_set_coeffs / coeff_in      : coefficient load stream
//           y_n / m_axis_fir_tvalid      : filter output, one cycle latency
//           coeffs_done                  : pulse after a full coefficient set
module fir_param #(
    parameter int TAP_SIZE    = 4,
    parameter int NBR_OF_TAPS = 4,
    parameter int X_N_SIZE    = 8,
    parameter int Y_N_SIZE    = 12
) (
    input  logic       clk,
    input  logic       reset,
    fir_param_if.slave bus
);
    localparam int ACC_W = TAP_SIZE + X_N_SIZE + $clog2(NBR_OF_TAPS);
    localparam int CNT_W = $clog2(NBR_OF_TAPS + 1);

    localparam logic signed [ACC_W-1:0] Y_MAX =
        ACC_W'((64'sd1 <<< (Y_N_SIZE - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN =
        ACC_W'(-(64'sd1 <<< (Y_N_SIZE - 1)));
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBR_OF_TAPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBR_OF_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CONFIG
    } state_t;

    state_t state_q, state_d;

    logic signed [TAP_SIZE-1:0] taps_q [NBR_OF_TAPS];
    logic signed [TAP_SIZE-1:0] taps_d [NBR_OF_TAPS];
    logic signed [X_N_SIZE-1:0] buff_q [NBR_OF_TAPS];
    logic signed [X_N_SIZE-1:0] buff_d [NBR_OF_TAPS];
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_base;
    logic signed [Y_N_SIZE-1:0] y_q, y_d;
    logic                       vld_q, vld_d;
    logic                       done_q, done_d;

    logic                       first_word;
    logic                       accept;
    logic signed [ACC_W-1:0]    acc;

    // ---------------- state machine: next state ----------------
    always_comb begin
        state_d = IDLE;
        if (bus.s_set_coeffs) begin
            state_d = CONFIG;
        end else if (bus.s_axis_fir_tvalid) begin
            state_d = ACTIVE;
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        taps_d   = taps_q;
        buff_d   = buff_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        y_d      = y_q;
        acc      = '0;

        first_word = bus.s_set_coeffs && (state_q != CONFIG);
        accept     = bus.s_axis_fir_tvalid && !bus.s_set_coeffs;
        vld_d      = accept;

        // A new burst restarts counting from zero regardless of what the
        // previous burst left in the counter.
        cnt_base = first_word ? '0 : cnt_q;

        if (bus.s_set_coeffs) begin
            for (int unsigned i = NBR_OF_TAPS - 1; i >= 1; i--) begin
                taps_d[i] = taps_q[i-1];
            end
            taps_d[0] = bus.coeff_in;
            if (first_word) begin
                for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
                    buff_d[i] = '0;
                end
            end
            // Counter saturates at NBR_OF_TAPS so overlong bursts give
            // exactly one pulse.
            if (cnt_base != CNT_FULL) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
            done_d = (cnt_base == CNT_LAST);
        end

        if (accept) begin
            for (int unsigned i = NBR_OF_TAPS - 1; i >= 1; i--) begin
                buff_d[i] = buff_q[i-1];
            end
            buff_d[0] = bus.x_n;
        end

        // Taps are stable whenever a sample is accepted, so the sum runs
        // over the current taps and the post-shift delay line.
        for (int unsigned k = 0; k < NBR_OF_TAPS; k++) begin
            acc = acc + ACC_W'(taps_q[k]) * ACC_W'(buff_d[k]);
        end

        if (accept) begin
            if (acc > Y_MAX) begin
                y_d = Y_MAX[Y_N_SIZE-1:0];
            end else if (acc < Y_MIN) begin
                y_d = Y_MIN[Y_N_SIZE-1:0];
            end else begin
                y_d = acc[Y_N_SIZE-1:0];
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
                taps_q[i] <= '0;
                buff_q[i] <= '0;
            end
            taps_q[0] <= TAP_SIZE'(1);
            cnt_q     <= '0;
            y_q       <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            buff_q  <= buff_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign bus.y_n               = y_q;
    assign bus.m_axis_fir_tvalid = vld_q;
    assign bus.coeffs_done       = done_q;

endmodule

// File: tb/tb_fir_param.sv
module tb_fir_param;
    localparam int TAP = 4;
    localparam int NT  = 4;
    localparam int XW  = 8;
    localparam int YW  = 12;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir_param_if #(.TAP_SIZE(TAP), .X_N_SIZE(XW), .Y_N_SIZE(YW)) ifc ();

    fir_param #(
        .TAP_SIZE   (TAP),
        .NBR_OF_TAPS(NT),
        .X_N_SIZE   (XW),
        .Y_N_SIZE   (YW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: coefficient list (newest word first), sample history
    // (newest sample first), word count of the current burst.
    int m_taps[$];
    int m_hist[$];
    int m_words;
    bit m_cfg;
    int m_y;
    int m_v;
    int m_d;

    typedef struct {
        bit rst;
        bit tv;
        bit sc;
        int x;
        int c;
        int ey;
        int ev;
        int ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        int lim;
        lim = 1 << (YW - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic model_reset();
        m_taps = {};
        m_hist = {};
        m_taps.push_back(1);
        for (int i = 1; i < NT; i++) m_taps.push_back(0);
        for (int i = 0; i < NT; i++) m_hist.push_back(0);
        m_words = 0;
        m_cfg   = 1'b0;
        m_y     = 0;
        m_v     = 0;
        m_d     = 0;
    endtask

    task automatic model_cycle(input bit rst, input bit tv, input bit sc,
                               input int x, input int c);
        int acc;
        if (rst) begin
            model_reset();
        end else if (sc) begin
            if (!m_cfg) begin
                m_words = 0;
                foreach (m_hist[i]) m_hist[i] = 0;
            end
            m_taps.push_front(c);
            void'(m_taps.pop_back());
            m_words++;
            m_d   = (m_words == NT) ? 1 : 0;
            m_v   = 0;
            m_cfg = 1'b1;
        end else begin
            m_cfg = 1'b0;
            m_d   = 0;
            m_v   = tv ? 1 : 0;
            if (tv) begin
                m_hist.push_front(x);
                void'(m_hist.pop_back());
                acc = 0;
                for (int k = 0; k < NT; k++) acc += m_taps[k] * m_hist[k];
                m_y = sat(acc);
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the
    // rising edge, and compare every output against the model.
    task automatic step(input bit rst, input bit tv, input bit sc,
                        input int x, input int c);
        @(negedge clk);
        reset                 = rst;
        ifc.s_axis_fir_tvalid = tv;
        ifc.s_set_coeffs      = sc;
        ifc.x_n               = XW'(x);
        ifc.coeff_in          = TAP'(c);
        @(posedge clk);
        #1;
        model_cycle(rst, tv, sc, x, c);
        check("model_y", int'(ifc.y_n), m_y);
        check("model_valid", int'(ifc.m_axis_fir_tvalid), m_v);
        check("model_done", int'(ifc.coeffs_done), m_d);
    endtask

    task automatic add(input bit rst, input bit tv, input bit sc, input int x,
                       input int c, input int ey, input int ev, input int ed);
        vec_t v;
        v = '{rst, tv, sc, x, c, ey, ev, ed};
        vecs.push_back(v);
    endtask

    task automatic samples(input int x, input int ey, input string name);
        step(0, 1, 0, x, 0);
        check({name, "_y"}, int'(ifc.y_n), ey);
        check({name, "_valid"}, int'(ifc.m_axis_fir_tvalid), 1);
    endtask

    int pulses;
    int burst_left;
    bit r_rst, r_tv, r_sc;

    initial begin
        reset                 = 1'b1;
        ifc.s_axis_fir_tvalid = 1'b0;
        ifc.s_set_coeffs      = 1'b0;
        ifc.x_n               = '0;
        ifc.coeff_in          = '0;
        model_reset();

        // ---- directed table: reset, identity, load 4,3,2,1, saturation ----
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 5, 0, 5, 1, 0);
        add(0, 0, 0, 0, 0, 5, 0, 0);
        add(0, 1, 0, -3, 0, -3, 1, 0);
        add(0, 0, 1, 0, 4, -3, 0, 0);
        add(0, 0, 1, 0, 3, -3, 0, 0);
        add(0, 0, 1, 0, 2, -3, 0, 0);
        add(0, 0, 1, 0, 1, -3, 0, 1);
        add(0, 1, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0, 3, 1, 0);
        add(0, 1, 0, 0, 0, 4, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 7, 0, 0, (i == 3) ? 1 : 0);
        add(0, 1, 0, 127, 0, 889, 1, 0);
        add(0, 1, 0, 127, 0, 1778, 1, 0);
        add(0, 1, 0, 127, 0, 2047, 1, 0);
        add(0, 1, 0, 127, 0, 2047, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, -8, 2047, 0, (i == 3) ? 1 : 0);
        add(0, 1, 0, 127, 0, -1016, 1, 0);
        add(0, 1, 0, 127, 0, -2032, 1, 0);
        add(0, 1, 0, 127, 0, -2048, 1, 0);
        add(0, 1, 0, 127, 0, -2048, 1, 0);
        add(0, 0, 0, 0, 0, -2048, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].tv, vecs[i].sc, vecs[i].x, vecs[i].c);
            check($sformatf("vec%0d_y", i), int'(ifc.y_n), vecs[i].ey);
            check($sformatf("vec%0d_valid", i), int'(ifc.m_axis_fir_tvalid), vecs[i].ev);
            check($sformatf("vec%0d_done", i), int'(ifc.coeffs_done), vecs[i].ed);
        end

        // ---- coefficient and sample in the same cycle ----
        step(1, 0, 0, 0, 0);
        samples(10, 10, "pre_a");
        samples(20, 20, "pre_b");
        step(0, 1, 1, 99, 2);
        check("both_high_valid", int'(ifc.m_axis_fir_tvalid), 0);
        check("both_high_y_hold", int'(ifc.y_n), 20);
        samples(0, 0, "both_high_cleared");
        samples(3, 6, "both_high_tap0");

        // ---- short burst then reset: identity restored, no pulse ----
        step(0, 0, 1, 0, 5);
        check("short_done_a", int'(ifc.coeffs_done), 0);
        step(0, 0, 1, 0, 6);
        check("short_done_b", int'(ifc.coeffs_done), 0);
        step(1, 0, 0, 0, 0);
        check("short_reset_done", int'(ifc.coeffs_done), 0);
        check("short_reset_y", int'(ifc.y_n), 0);
        samples(9, 9, "identity_impulse");

        // ---- six-word burst: one pulse, last four words kept ----
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1, 0, i);
            pulses += int'(ifc.coeffs_done);
            check($sformatf("burst6_done_w%0d", i), int'(ifc.coeffs_done), (i == 4) ? 1 : 0);
        end
        check("burst6_pulses", pulses, 1);
        samples(1, 6, "burst6_t0");
        samples(0, 5, "burst6_t1");
        samples(0, 4, "burst6_t2");
        samples(0, 3, "burst6_t3");

        // ---- randomized traffic against the model ----
        burst_left = 0;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            if (burst_left > 0) begin
                r_sc = 1'b1;
                burst_left--;
            end else if ($urandom_range(0, 99) < 8) begin
                r_sc       = 1'b1;
                burst_left = $urandom_range(0, 6);
            end else begin
                r_sc = 1'b0;
            end
            r_tv = ($urandom_range(0, 3) != 0);
            step(r_rst, r_tv, r_sc, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 15) - 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 The block SHALL have parameter TAP_SIZE, default 4: signed coefficient width in bits.
REQ-002 The block SHALL have parameter NBR_OF_TAPS, default 4: number of taps, 2..32.
REQ-003 The block SHALL have parameter X_N_SIZE, default 8: signed sample width in bits.
REQ-004 The block SHALL have parameter Y_N_SIZE, default 12: signed output width in bits, 2..TAP_SIZE+X_N_SIZE+clog2(NBR_OF_TAPS).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port x_n, input, X_N_SIZE bits: signed input sample.
REQ-008 The block SHALL have port s_axis_fir_tvalid, input, 1 bit: x_n is valid this cycle.
REQ-009 The block SHALL have port s_set_coeffs, input, 1 bit: coeff_in is valid this cycle and coefficient loading is active.
REQ-010 The block SHALL have port coeff_in, input, TAP_SIZE bits: signed coefficient word.
REQ-011 The block SHALL have port y_n, output, Y_N_SIZE bits: signed, saturated filter output.
REQ-012 The block SHALL have port m_axis_fir_tvalid, output, 1 bit: y_n is new this cycle.
REQ-013 The block SHALL have port coeffs_done, output, 1 bit: one-cycle pulse when the NBR_OF_TAPS-th coefficient of a load burst is accepted.

Function
REQ-014 The block SHALL hold a state register with states IDLE, ACTIVE and CONFIG; next state is CONFIG if s_set_coeffs=1, else ACTIVE if s_axis_fir_tvalid=1, else IDLE.
REQ-015 The block SHALL give s_set_coeffs priority when it and s_axis_fir_tvalid are high in the same cycle; the sample is dropped and produces no output.
REQ-016 In each cycle with s_set_coeffs=1, the block SHALL shift taps[i]<=taps[i-1] for i=1..NBR_OF_TAPS-1 and load taps[0]<=coeff_in; the first word of a burst therefore ends in taps[NBR_OF_TAPS-1].
REQ-017 On the first cycle of a CONFIG burst (state not CONFIG, s_set_coeffs=1), the block SHALL clear every delay-line entry to 0.
REQ-018 The block SHALL count accepted coefficients per burst, restarting at 1 on each burst's first word, and pulse coeffs_done for one cycle on the cycle after the NBR_OF_TAPS-th word; the counter SHALL saturate, and extra words SHALL keep shifting without a further pulse.
REQ-019 A burst shorter than NBR_OF_TAPS SHALL leave the partially shifted taps in place with no coeffs_done pulse.
REQ-020 A sample SHALL be accepted when s_axis_fir_tvalid=1 and s_set_coeffs=0: buff[0]<=x_n and buff[i]<=buff[i-1].
REQ-021 For each accepted sample, the block SHALL compute sum(taps[k]*buff'[k]), k=0..NBR_OF_TAPS-1, over the post-shift delay line at full precision (TAP_SIZE+X_N_SIZE+clog2(NBR_OF_TAPS) bits, signed).
REQ-022 The block SHALL saturate the full-precision sum to the Y_N_SIZE signed range, max 2^(Y_N_SIZE-1)-1 and min -2^(Y_N_SIZE-1), register it on y_n, and assert m_axis_fir_tvalid for exactly one cycle, 1 cycle after acceptance.
REQ-023 Back-to-back accepted samples SHALL produce back-to-back outputs, one per cycle, with no bubbles.
REQ-024 When no sample is accepted, y_n SHALL hold its last value and m_axis_fir_tvalid SHALL be 0.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL set state=IDLE, every delay-line entry to 0, taps[0]=1, all other taps to 0 (identity filter), the coefficient counter to 0, y_n=0, m_axis_fir_tvalid=0 and coeffs_done=0.
REQ-026 Reset SHALL override all other inputs in the same cycle; reset during a CONFIG burst SHALL discard the partial load and restore the identity taps.
REQ-027 Operation after reset deasserts SHALL begin on the first edge with reset=0; no setup cycles are required.

Verification
REQ-028 A bench SHALL cover: after reset, x_n=5 valid for 1 cycle -> next cycle y_n=5 with m_axis_fir_tvalid=1; then x_n=-3 -> y_n=-3.
REQ-029 A bench SHALL cover: load coeff_in 4,3,2,1 over 4 cycles -> coeffs_done pulses once; then feed samples 1,0,0,0,0 -> y_n sequence 1,2,3,4,0.
REQ-030 A bench SHALL cover: taps all 7, four samples of 127 -> 4th output is 3556, saturated to 2047; taps all -8, four samples of 127 -> -2048.
REQ-031 A bench SHALL cover: s_set_coeffs and s_axis_fir_tvalid both high for 1 cycle -> tap shift occurs, delay line cleared, no m_axis_fir_tvalid pulse.
REQ-032 A bench SHALL cover: burst of 2 coefficients (5,6), then reset -> no coeffs_done pulse; impulse x_n=9 afterwards -> y_n=9 (identity restored).
REQ-033 A bench SHALL cover: 6-word burst with NBR_OF_TAPS=4 -> exactly one coeffs_done pulse, and taps hold the last 4 words.
